mc_main_control: RTL and testbench
==================================

// Module: mc_main_control
// PURPOSE
//  Multicycle main control FSM for the 32-bit MIPS core. Sits directly upstream of alu_control.
//  Decodes opcode[31:26] into per-state datapath enables and the 3-bit alu_op consumed there.
//  Stretches memory states on a ready handshake and aborts hung accesses with a timeout.
// PARAMETERS
//  MEM_TIMEOUT  255  max wait cycles in a memory state with mem_ready=0; 0 disables the timeout
// PORTS
//  clk          in   1  core clock, rising edge
//  reset        in   1  asynchronous, active-high reset
//  opcode       in   6  instr[31:26] from IR; stable from DECODE onward
//  mem_ready    in   1  memory access completes this cycle
//  pc_write     out  1  unconditional PC load
//  pc_write_cond out 1  PC load if ALU zero (beq)
//  iord         out  1  mem addr: 0=PC, 1=ALUOut
//  mem_read     out  1  memory read request
//  mem_write    out  1  memory write request
//  ir_write     out  1  load IR
//  reg_dst      out  1  write reg: 0=rt, 1=rd
//  mem_to_reg   out  1  wb data: 0=ALUOut, 1=MDR
//  reg_write    out  1  register file write
//  alu_src_a    out  1  ALU A: 0=PC, 1=rs
//  alu_src_b    out  2  ALU B: 00=rt 01=4 10=signext imm 11=signext imm<<2
//  pc_src       out  2  next PC: 00=ALU 01=ALUOut 10=jump target
//  alu_op       out  3  to alu_control: 000=add 001=sub 010=R-type funct
//  state        out  4  current state code (debug/verification)
//  illegal_op   out  1  1-cycle pulse: unsupported opcode decoded
//  mem_timeout  out  1  1-cycle pulse: memory wait aborted
// BEHAVIOUR
//  States: RST=0 FETCH=1 DECODE=2 MEMADR=3 MEMRD=4 MEMWB=5 MEMWR=6 EXEC=7 ALUWB=8 BRANCH=9
//    ADDIEX=10 ADDIWB=11 JUMP=12; codes 13-15 unreachable and go to FETCH.
//  Reset: state=RST and every output is 0, including the pulses. RST always advances to FETCH.
//  Moore outputs decoded from state; an output not listed for a state is 0:
//   FETCH : mem_read=1, alu_src_b=01, alu_op=000; ir_write=pc_write=mem_ready (qualified)
//   DECODE: alu_src_b=11, alu_op=000 (branch target precompute)
//   MEMADR/ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=000
//   MEMRD : iord=1, mem_read=1 | MEMWR: iord=1, mem_write=1
//   MEMWB : mem_to_reg=1, reg_write=1 | ALUWB: reg_dst=1, reg_write=1 | ADDIWB: reg_write=1
//   EXEC  : alu_src_a=1, alu_op=010
//   BRANCH: alu_src_a=1, alu_op=001, pc_write_cond=1, pc_src=01
//   JUMP  : pc_write=1, pc_src=10
//  Transitions:
//   FETCH->DECODE on mem_ready.
//   DECODE by opcode: 100011 lw / 101011 sw->MEMADR; 000000->EXEC; 000100->BRANCH;
//     001000->ADDIEX; 000010->JUMP; any other opcode->FETCH with illegal_op=1 on that edge.
//   MEMADR->MEMRD (lw) or MEMWR (sw), selected by opcode.
//   MEMRD->MEMWB on mem_ready; MEMWR->FETCH on mem_ready.
//   MEMWB, ALUWB, ADDIWB, BRANCH, JUMP->FETCH; EXEC->ALUWB; ADDIEX->ADDIWB.
//  Wait counter (8b min, saturating): clears on each state change; increments each cycle in
//   FETCH/MEMRD/MEMWR with mem_ready=0. When it equals MEM_TIMEOUT (MEM_TIMEOUT!=0) with
//   mem_ready still 0, next state=FETCH, mem_timeout pulses 1 cycle, counter clears.
//  mem_ready=1 on the same cycle the counter hits the limit: completion wins, no timeout.
//  FETCH timeout re-enters FETCH with a fresh count and no ir_write/pc_write.
//  Pulses are registered: asserted in the cycle after the triggering edge condition.
//  Async reset mid-instruction: immediate return to RST; no partial write completes.
//  Total cycles with zero wait: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
// TESTING
//  reset high, then release with mem_ready=1 -> state 0 during reset, then 1, all outputs 0 in RST.
//  lw (100011), mem_ready=1 -> states 1,2,3,4,5,1; reg_write+mem_to_reg only in MEMWB;
//    alu_op 000 throughout.
//  R-type (000000) then beq (000100) -> alu_op=010 in EXEC; alu_op=001 and pc_write_cond=1 in BRANCH.
//  sw with mem_ready low 3 cycles in MEMWR -> 3 extra MEMWR cycles, mem_write held, then FETCH.
//  MEM_TIMEOUT=4, mem_ready stuck 0 in MEMRD -> FETCH after timeout, mem_timeout 1-cycle pulse,
//    no reg_write.
//  opcode 111111 in DECODE -> illegal_op pulse, back to FETCH; reset asserted in EXEC -> state 0.

Source files
------------

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: opcode decode into per-state datapath enables,
// with memory-state stretching on mem_ready and a wait-cycle timeout abort.
module mc_main_control #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 255) ? $clog2(MEM_TIMEOUT + 1) : 8;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    // Datapath control word driven out of the per-state decode
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
    } ctrl_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_wait;
    logic             wait_hit;
    logic             illegal_d;
    logic             timeout_d;
    logic             illegal_q;
    logic             timeout_q;
    ctrl_t            ctrl;

    assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                      && !mem_ready;
    // A completing access on the limit cycle wins over the timeout
    assign wait_hit = (MEM_TIMEOUT != 32'd0) && (wait_cnt == CNT_W'(MEM_TIMEOUT)) && mem_wait;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and pulse triggers
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_hit) begin
                    state_d   = S_FETCH;
                    timeout_d = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (wait_hit) begin
                    state_d   = S_FETCH;
                    timeout_d = 1'b1;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (wait_hit) begin
                    state_d   = S_FETCH;
                    timeout_d = 1'b1;
                end
            end
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Saturating wait counter; a FETCH timeout re-enters FETCH so it clears explicitly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if ((state_d != state_q) || timeout_d) begin
            wait_cnt <= '0;
        end else if (mem_wait && (wait_cnt != {CNT_W{1'b1}})) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Registered status pulses, visible the cycle after their trigger
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Moore decode of datapath enables from the current state
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'b11;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = 2'b01;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = 2'b10;
            end
            default: ctrl = '0;
        endcase
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign pc_src        = ctrl.pc_src;
    assign alu_op        = ctrl.alu_op;
    assign state         = 4'(state_q);
    assign illegal_op    = illegal_q;
    assign mem_timeout   = timeout_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Self-checking bench for mc_main_control: per-cycle expected state/control word queued
// at stimulus time and compared on the falling edge.
module tb_mc_main_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic       illegal_op, mem_timeout;

    int n_checks = 0;
    int n_errors = 0;

    mc_main_control #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_op(alu_op), .state(state), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [18:0] outs;
    } exp_t;

    typedef struct {
        logic [5:0]  op;
        int          len;
        logic [27:0] seq;
        logic        ill;
    } vec_t;

    exp_t exp_q[$];

    function automatic logic [18:0] act_outs();
        return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src, alu_op,
                illegal_op, mem_timeout};
    endfunction

    // Expected control word per state, straight from the state/output table
    function automatic logic [18:0] outs_for(input logic [3:0] st, input logic rdy,
                                             input logic ill, input logic to);
        logic pcw, pwc, io, mr, mw, irw, rd, m2r, rw, asa;
        logic [1:0] asb, psrc;
        logic [2:0] aop;
        {pcw, pwc, io, mr, mw, irw, rd, m2r, rw, asa} = '0;
        asb = 2'b00; psrc = 2'b00; aop = 3'b000;
        case (st)
            4'd1:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            4'd2:  asb = 2'b11;
            4'd3, 4'd10: begin asa = 1; asb = 2'b10; end
            4'd4:  begin io = 1; mr = 1; end
            4'd5:  begin m2r = 1; rw = 1; end
            4'd6:  begin io = 1; mw = 1; end
            4'd7:  begin asa = 1; aop = 3'b010; end
            4'd8:  begin rd = 1; rw = 1; end
            4'd9:  begin asa = 1; aop = 3'b001; pwc = 1; psrc = 2'b01; end
            4'd11: rw = 1;
            4'd12: begin pcw = 1; psrc = 2'b10; end
            default: ;
        endcase
        return {pcw, pwc, io, mr, mw, irw, rd, m2r, rw, asa, asb, psrc, aop, ill, to};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge: apply inputs for this cycle and queue expectations
    task automatic drive(input string name, input logic rdy, input logic [5:0] op,
                         input logic [3:0] st, input logic ill, input logic to);
        exp_t e;
        mem_ready = rdy;
        opcode    = op;
        e.name = name;
        e.st   = st;
        e.outs = outs_for(st, rdy, ill, to);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, " state"}, 32'(state), 32'(e.st));
            check({e.name, " ctrl"}, 32'(act_outs()), 32'(e.outs));
        end
    end

    vec_t vecs[10];
    logic prev_ill;

    initial begin
        vecs[0] = '{6'b100011, 5, 28'h0054321, 1'b0}; // lw
        vecs[1] = '{6'b101011, 4, 28'h0006321, 1'b0}; // sw
        vecs[2] = '{6'b000000, 4, 28'h0008721, 1'b0}; // R-type
        vecs[3] = '{6'b000100, 3, 28'h0000921, 1'b0}; // beq
        vecs[4] = '{6'b001000, 4, 28'h000BA21, 1'b0}; // addi
        vecs[5] = '{6'b000010, 3, 28'h0000C21, 1'b0}; // j
        vecs[6] = '{6'b111111, 2, 28'h0000021, 1'b1}; // illegal
        vecs[7] = '{6'b100011, 5, 28'h0054321, 1'b0}; // lw after illegal
        vecs[8] = '{6'b001101, 2, 28'h0000021, 1'b1}; // ori: unsupported
        vecs[9] = '{6'b000000, 4, 28'h0008721, 1'b0}; // R-type

        reset = 1'b1; opcode = 6'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", 32'(state), 32'd0);
        check("reset ctrl", 32'(act_outs()), 32'd0);
        reset = 1'b0;
        drive("rst cycle", 1'b1, 6'b0, 4'd0, 1'b0, 1'b0);

        prev_ill = 1'b0;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < vecs[i].len; k++) begin
                logic [27:0] s;
                s = vecs[i].seq;
                drive($sformatf("vec%0d c%0d", i, k), 1'b1, vecs[i].op, s[4*k +: 4],
                      (k == 0) && prev_ill, 1'b0);
            end
            prev_ill = vecs[i].ill;
        end

        // sw with 3 wait cycles in MEMWR
        drive("swwait f", 1'b1, 6'b101011, 4'd1, 1'b0, 1'b0);
        drive("swwait d", 1'b1, 6'b101011, 4'd2, 1'b0, 1'b0);
        drive("swwait a", 1'b1, 6'b101011, 4'd3, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) drive("swwait w0", 1'b0, 6'b101011, 4'd6, 1'b0, 1'b0);
        drive("swwait w1", 1'b1, 6'b101011, 4'd6, 1'b0, 1'b0);

        // lw hung in MEMRD: count 0..4 then abort to FETCH with a pulse
        drive("lwto f", 1'b1, 6'b100011, 4'd1, 1'b0, 1'b0);
        drive("lwto d", 1'b1, 6'b100011, 4'd2, 1'b0, 1'b0);
        drive("lwto a", 1'b1, 6'b100011, 4'd3, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) drive("lwto rd", 1'b0, 6'b100011, 4'd4, 1'b0, 1'b0);
        drive("lwto pulse", 1'b1, 6'b100011, 4'd1, 1'b0, 1'b1);

        // completion on the limit cycle wins
        drive("lwlim d", 1'b1, 6'b100011, 4'd2, 1'b0, 1'b0);
        drive("lwlim a", 1'b1, 6'b100011, 4'd3, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) drive("lwlim rd0", 1'b0, 6'b100011, 4'd4, 1'b0, 1'b0);
        drive("lwlim rd1", 1'b1, 6'b100011, 4'd4, 1'b0, 1'b0);
        drive("lwlim wb", 1'b1, 6'b100011, 4'd5, 1'b0, 1'b0);

        // FETCH timeout re-enters FETCH, then a fresh count allows another full wait
        for (int k = 0; k < 5; k++) drive("fto wait", 1'b0, 6'b000100, 4'd1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) drive("fto again", 1'b0, 6'b000100, 4'd1, 1'b0, k == 0);
        drive("fto go", 1'b1, 6'b000100, 4'd1, 1'b0, 1'b0);
        drive("fto dec", 1'b1, 6'b000100, 4'd2, 1'b0, 1'b0);
        drive("fto br", 1'b1, 6'b000100, 4'd9, 1'b0, 1'b0);

        // async reset in EXEC
        drive("rexe f", 1'b1, 6'b000000, 4'd1, 1'b0, 1'b0);
        drive("rexe d", 1'b1, 6'b000000, 4'd2, 1'b0, 1'b0);
        check("in exec", 32'(state), 32'd7);
        reset = 1'b1;
        #1;
        check("async reset state", 32'(state), 32'd0);
        check("async reset ctrl", 32'(act_outs()), 32'd0);
        @(posedge clk);
        #1;
        check("held reset state", 32'(state), 32'd0);
        reset = 1'b0;
        drive("post rst", 1'b1, 6'b000010, 4'd0, 1'b0, 1'b0);
        drive("post f", 1'b1, 6'b000010, 4'd1, 1'b0, 1'b0);
        drive("post d", 1'b1, 6'b000010, 4'd2, 1'b0, 1'b0);
        drive("post j", 1'b1, 6'b000010, 4'd12, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        check("queue drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
